adder_32: RTL and testbench



---
 rtl/adder_pkg.sv | 15 +
 rtl/adder_32_cla4.sv | 37 +++
 rtl/adder_32.sv | 107 ++++++++++
 tb/tb_adder_32.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants and helpers for the carry-lookahead adder.
package adder_pkg;

  // Width of one first-level lookahead group.
  localparam int ADDER_GROUP = 4;

  // Operand width used when the adder is not parameterised explicitly.
  localparam int ADDER_DEFAULT_WIDTH = 32;

  // Number of 4-bit lookahead groups needed to cover a given operand width.
  function automatic int adder_groups(input int width);
    return width / ADDER_GROUP;
  endfunction

endpackage

// File: rtl/adder_32_cla4.sv
// cla4: 4-bit carry-lookahead slice. Produces the slice sum from its own
// carry-in, plus group generate/propagate for the second lookahead level.
module cla4
  import adder_pkg::*;
(
  input  logic [ADDER_GROUP-1:0] a,
  input  logic [ADDER_GROUP-1:0] b,
  input  logic                   cin,
  output logic [ADDER_GROUP-1:0] sum,
  output logic                   g_grp,
  output logic                   p_grp
);

  logic [ADDER_GROUP-1:0] g;
  logic [ADDER_GROUP-1:0] p;
  logic [ADDER_GROUP-1:0] c;

  // Bit-level generate/propagate, flat lookahead carries, and group G/P.
  always_comb begin
    g = a & b;
    p = a ^ b;

    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);

    sum = p ^ c;

    // Group G/P deliberately exclude cin so the next level can flatten carries.
    g_grp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0]);
    p_grp = &p;
  end

endmodule

// File: rtl/adder_32.sv
// adder_32: WIDTH-bit two-level carry-lookahead adder (a + b + cin) with a
// combinational result/carry and a one-cycle registered copy.
// WIDTH must be a multiple of 4 and at least 4.
// Optional feature macro ADDER_OVF_EN adds o_ovf / o_ovf_q (signed overflow).
module adder_32
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cout,
  output logic [WIDTH-1:0] o_result_q,
  output logic             o_cout_q,
  output logic             o_valid_q
`ifdef ADDER_OVF_EN
  ,
  output logic             o_ovf,
  output logic             o_ovf_q
`endif
);

  localparam int NUM_GROUPS = adder_groups(WIDTH);

  logic [NUM_GROUPS-1:0] g_grp;
  logic [NUM_GROUPS-1:0] p_grp;
  logic [NUM_GROUPS:0]   c_grp;
  logic [WIDTH-1:0]      sum;
  logic                  carry_acc;
  logic                  prop_run;

  // First lookahead level: one cla4 per 4-bit slice.
  for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_slice
    cla4 u_cla4 (
      .a     (i_a[gi*ADDER_GROUP +: ADDER_GROUP]),
      .b     (i_b[gi*ADDER_GROUP +: ADDER_GROUP]),
      .cin   (c_grp[gi]),
      .sum   (sum[gi*ADDER_GROUP +: ADDER_GROUP]),
      .g_grp (g_grp[gi]),
      .p_grp (p_grp[gi])
    );
  end

  // Second lookahead level: each group carry is a flat sum of products of the
  // lower groups' G/P and i_cin, so no carry ripples from group to group.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which is what would otherwise infer a latch.
    c_grp     = '0;
    carry_acc = 1'b0;
    prop_run  = 1'b1;
    c_grp[0]  = i_cin;
    for (int k = 1; k <= NUM_GROUPS; k++) begin
      carry_acc = 1'b0;
      prop_run  = 1'b1;
      for (int j = k - 1; j >= 0; j--) begin
        carry_acc = carry_acc | (g_grp[j] & prop_run);
        prop_run  = prop_run & p_grp[j];
      end
      c_grp[k] = carry_acc | (prop_run & i_cin);
    end
  end

  assign o_result = sum;
  assign o_cout   = c_grp[NUM_GROUPS];

`ifdef ADDER_OVF_EN
  logic msb_cin;

  // Carry into the MSB recovered from its sum bit; overflow is that XOR carry-out.
  always_comb begin
    msb_cin = i_a[WIDTH-1] ^ i_b[WIDTH-1] ^ sum[WIDTH-1];
    o_ovf   = msb_cin ^ o_cout;
  end
`endif

  // Output registers: reset wins over enable; valid marks the cycle after i_en.
  always_ff @(posedge i_clk) begin
    // NOTE: reset is synchronous and only touches these registers; the
    // combinational sum keeps tracking its inputs during reset.
    if (i_rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      o_result_q <= '0;
      o_cout_q   <= 1'b0;
      o_valid_q  <= 1'b0;
`ifdef ADDER_OVF_EN
      o_ovf_q    <= 1'b0;
`endif
    end else if (i_en) begin
      o_result_q <= o_result;
      o_cout_q   <= o_cout;
      o_valid_q  <= 1'b1;
`ifdef ADDER_OVF_EN
      o_ovf_q    <= o_ovf;
`endif
    end else begin
      o_valid_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_32.sv
// tb_adder_32: self-checking bench for adder_32. An arithmetic reference model
// is compared with the DUT on every falling edge; directed vectors carry
// hand-computed literal expectations. Honours ADDER_OVF_EN if defined.
module tb_adder_32;

  localparam int W = 32;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_en;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         i_cin;
  logic [W-1:0] o_result;
  logic         o_cout;
  logic [W-1:0] o_result_q;
  logic         o_cout_q;
  logic         o_valid_q;
`ifdef ADDER_OVF_EN
  logic         o_ovf;
  logic         o_ovf_q;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  adder_32 #(.WIDTH(W)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (i_en),
    .i_a        (i_a),
    .i_b        (i_b),
    .i_cin      (i_cin),
    .o_result   (o_result),
    .o_cout     (o_cout),
    .o_result_q (o_result_q),
    .o_cout_q   (o_cout_q),
    .o_valid_q  (o_valid_q)
`ifdef ADDER_OVF_EN
    ,
    .o_ovf      (o_ovf),
    .o_ovf_q    (o_ovf_q)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain (W+1)-bit unsigned addition.
  function automatic logic [W:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  // Reference signed overflow: like-signed operands giving a differently signed result.
  function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic cin);
    logic [W:0] s;
    s = model_sum(a, b, cin);
    return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endfunction

  logic [W-1:0] exp_result_q;
  logic         exp_cout_q;
  logic         exp_valid_q;
  logic         exp_ovf_q;
  logic         model_on = 1'b0;

  // Expected registered outputs, updated from the inputs present at each edge.
  always @(posedge i_clk) begin
    if (i_rst) begin
      exp_result_q <= '0;
      exp_cout_q   <= 1'b0;
      exp_valid_q  <= 1'b0;
      exp_ovf_q    <= 1'b0;
      model_on     <= 1'b1;
    end else if (i_en) begin
      {exp_cout_q, exp_result_q} <= model_sum(i_a, i_b, i_cin);
      exp_valid_q  <= 1'b1;
      exp_ovf_q    <= model_ovf(i_a, i_b, i_cin);
    end else begin
      exp_valid_q  <= 1'b0;
    end
  end

  // Compare process: every falling edge once the model is anchored by reset.
  always @(negedge i_clk) begin
    logic [W:0] s;
    if (model_on) begin
      s = model_sum(i_a, i_b, i_cin);
      check("cmp_result",   o_result,   s[W-1:0]);
      check("cmp_cout",     o_cout,     s[W]);
      check("cmp_result_q", o_result_q, exp_result_q);
      check("cmp_cout_q",   o_cout_q,   exp_cout_q);
      check("cmp_valid_q",  o_valid_q,  exp_valid_q);
`ifdef ADDER_OVF_EN
      check("cmp_ovf",      o_ovf,      model_ovf(i_a, i_b, i_cin));
      check("cmp_ovf_q",    o_ovf_q,    exp_ovf_q);
`endif
    end
  end

  // Drive one vector just after a rising edge, then wait for the falling edge.
  task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic en, input logic rst);
    @(posedge i_clk);
    #1;
    i_a   = a;
    i_b   = b;
    i_cin = cin;
    i_en  = en;
    i_rst = rst;
    @(negedge i_clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] diff;

    i_rst = 1'b1;
    i_en  = 1'b0;
    i_a   = '0;
    i_b   = '0;
    i_cin = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("reset_result_q", o_result_q, 0);
    check("reset_cout_q",   o_cout_q,   0);
    check("reset_valid_q",  o_valid_q,  0);

    // Combinational literals.
    apply(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    check("all_ones_plus_cin_res",  o_result, 32'h0000_0000);
    check("all_ones_plus_cin_cout", o_cout,   1);
    apply(32'd5, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    check("sub_5_3_res",  o_result, 32'h0000_0002);
    check("sub_5_3_cout", o_cout,   1);
    apply(32'd3, 32'hFFFF_FFFA, 1'b1, 1'b0, 1'b0);
    check("sub_3_5_res",  o_result, 32'hFFFF_FFFE);
    check("sub_3_5_cout", o_cout,   0);
    apply(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    check("max_pos_plus1_res",  o_result, 32'h8000_0000);
    check("max_pos_plus1_cout", o_cout,   0);
`ifdef ADDER_OVF_EN
    check("max_pos_plus1_ovf",  o_ovf,    1);
`endif
    apply(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    check("zero_res",  o_result, 32'h0000_0000);
    check("zero_cout", o_cout,   0);
    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    check("max_sum_res",  o_result, 32'hFFFF_FFFF);
    check("max_sum_cout", o_cout,   1);

    // Registered path: load, then hold with valid dropping.
    apply(32'h10, 32'h20, 1'b0, 1'b1, 1'b0);
    check("en_comb_res", o_result, 32'h30);
    apply(32'h1, 32'h1, 1'b0, 1'b0, 1'b0);
    check("en_result_q", o_result_q, 32'h30);
    check("en_valid_q",  o_valid_q,  1);
    apply(32'h2, 32'h2, 1'b0, 1'b0, 1'b0);
    check("hold_result_q", o_result_q, 32'h30);
    check("hold_valid_q",  o_valid_q,  0);

    // Reset mid-stream, with enable high and a carry-out registered.
    apply(32'h8000_0000, 32'h8000_0100, 1'b0, 1'b1, 1'b0);
    apply(32'h11, 32'h22, 1'b0, 1'b1, 1'b1);
    check("pre_rst_result_q", o_result_q, 32'h100);
    check("pre_rst_cout_q",   o_cout_q,   1);
    check("pre_rst_valid_q",  o_valid_q,  1);
    check("in_rst_comb_res",  o_result,   32'h33);
    apply(32'h40, 32'h2, 1'b0, 1'b1, 1'b1);
    check("rst_result_q", o_result_q, 0);
    check("rst_cout_q",   o_cout_q,   0);
    check("rst_valid_q",  o_valid_q,  0);
    check("rst_comb_res", o_result,   32'h42);

    // Random subtractions with a random enable pattern.
    for (int i = 0; i < 10000; i++) begin
      ra   = $urandom;
      rb   = $urandom;
      diff = ra - rb;
      apply(ra, ~rb, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      check("sub_rand_res",    o_result, diff);
      check("sub_rand_borrow", o_cout,   (ra >= rb) ? 1 : 0);
    end

    @(posedge i_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
